// File: rtl/axi_log_pkg.sv
// axi_log_pkg: shared types and constants for the AXI address-channel logger.
package axi_log_pkg;
   localparam int ID_BITW       = 8;
   localparam int ADDR_BITW     = 32;
   localparam int LEN_BITW      = 8;
   localparam int DROP_CNT_BITW = 16;
   typedef struct packed {
      logic [ID_BITW-1:0]   id;
      logic [ADDR_BITW-1:0] addr;
      logic [LEN_BITW-1:0]  len;
      logic                 is_write;
   } log_entry_t;
endpackage

// File: rtl/axi_log_fifo.sv
// axi_log_fifo: per-channel capture FIFO; the caller gates push so a full FIFO only takes data while it pops.
module axi_log_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) if (push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/axi_log_arbiter.sv
// axi_log_arbiter: passive AW/AR snooper merging both channels into one log stream with alternating priority.
// Drop counter is built only with AXI_LOG_ARBITER_DROP_CNT_EN defined; otherwise DropCnt_DO is tied to 0.
module axi_log_arbiter import axi_log_pkg::*; #(
   parameter int AXI_ADDR_BITW = 32,
   parameter int AXI_ID_BITW   = 8,
   parameter int AXI_LEN_BITW  = 8,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     Clk_CI,
   input  logic                     Rst_RI,
   input  logic                     AwValid_SI,
   input  logic                     AwReady_SI,
   input  logic [AXI_ID_BITW-1:0]   AwId_DI,
   input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
   input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
   input  logic                     ArValid_SI,
   input  logic                     ArReady_SI,
   input  logic [AXI_ID_BITW-1:0]   ArId_DI,
   input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
   input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
   input  logic                     Clear_SI,
   output logic                     LogValid_SO,
   output logic [AXI_ID_BITW-1:0]   LogId_DO,
   output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
   output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
   output logic                     LogIsWrite_SO,
   output logic [DROP_CNT_BITW-1:0] DropCnt_DO
);
   localparam int EW = AXI_ID_BITW + AXI_ADDR_BITW + AXI_LEN_BITW;
   logic          aw_cap, ar_cap, aw_push, ar_push, aw_pop, ar_pop;
   logic          aw_full, ar_full, aw_empty, ar_empty, prio_ar;
   logic [EW-1:0] aw_dout, ar_dout, sel;
   assign aw_cap  = AwValid_SI & AwReady_SI & ~Clear_SI;
   assign ar_cap  = ArValid_SI & ArReady_SI & ~Clear_SI;
   assign aw_pop  = ~Clear_SI & ~aw_empty & (ar_empty | ~prio_ar);
   assign ar_pop  = ~Clear_SI & ~ar_empty & (aw_empty | prio_ar);
   assign aw_push = aw_cap & (~aw_full | aw_pop);
   assign ar_push = ar_cap & (~ar_full | ar_pop);
   assign sel     = aw_pop ? aw_dout : ar_dout;
   axi_log_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
      .clk(Clk_CI), .rst(Rst_RI), .clear(Clear_SI), .push(aw_push), .pop(aw_pop),
      .din({AwId_DI, AwAddr_DI, AwLen_DI}), .dout(aw_dout), .full(aw_full), .empty(aw_empty)
   );
   axi_log_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
      .clk(Clk_CI), .rst(Rst_RI), .clear(Clear_SI), .push(ar_push), .pop(ar_pop),
      .din({ArId_DI, ArAddr_DI, ArLen_DI}), .dout(ar_dout), .full(ar_full), .empty(ar_empty)
   );
   // Priority only flips when both channels competed in this cycle
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         prio_ar       <= 1'b0;
         LogValid_SO   <= 1'b0;
         LogId_DO      <= '0;
         LogAddr_DO    <= '0;
         LogLen_DO     <= '0;
         LogIsWrite_SO <= 1'b0;
      end else begin
         LogValid_SO <= aw_pop | ar_pop;
         prio_ar     <= Clear_SI ? 1'b0 : (aw_pop & ~ar_empty) ? 1'b1 : (ar_pop & ~aw_empty) ? 1'b0 : prio_ar;
         if (aw_pop || ar_pop) begin
            {LogId_DO, LogAddr_DO, LogLen_DO} <= sel;
            LogIsWrite_SO <= aw_pop;
         end
      end
   end
`ifdef AXI_LOG_ARBITER_DROP_CNT_EN
   logic [1:0]               drops;
   logic [DROP_CNT_BITW:0]   drop_sum;
   assign drops    = {1'b0, aw_cap & ~aw_push} + {1'b0, ar_cap & ~ar_push};
   assign drop_sum = {1'b0, DropCnt_DO} + {{(DROP_CNT_BITW-1){1'b0}}, drops};
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI || Clear_SI) DropCnt_DO <= '0;
      else DropCnt_DO <= drop_sum[DROP_CNT_BITW] ? '1 : drop_sum[DROP_CNT_BITW-1:0];
   end
`else
   assign DropCnt_DO = '0;
`endif
endmodule

// File: tb/tb_axi_log_arbiter.sv
// tb_axi_log_arbiter: directed checks of capture latency, arbitration, drops and clear.
module tb_axi_log_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        aw_valid = 1'b0, aw_ready = 1'b0, ar_valid = 1'b0, ar_ready = 1'b0, clear = 1'b0;
   logic [7:0]  aw_id = '0, ar_id = '0, aw_len = '0, ar_len = '0;
   logic [31:0] aw_addr = '0, ar_addr = '0;
   logic        log_valid, log_is_write;
   logic [7:0]  log_id, log_len;
   logic [31:0] log_addr;
   logic [15:0] drop_cnt;
   int          n_chk = 0, n_bad = 0;
`ifdef AXI_LOG_ARBITER_DROP_CNT_EN
   localparam int EXP_DROP = 3;
`else
   localparam int EXP_DROP = 0;
`endif
   always #5 clk = ~clk;
   axi_log_arbiter dut (
      .Clk_CI(clk), .Rst_RI(rst),
      .AwValid_SI(aw_valid), .AwReady_SI(aw_ready), .AwId_DI(aw_id), .AwAddr_DI(aw_addr), .AwLen_DI(aw_len),
      .ArValid_SI(ar_valid), .ArReady_SI(ar_ready), .ArId_DI(ar_id), .ArAddr_DI(ar_addr), .ArLen_DI(ar_len),
      .Clear_SI(clear), .LogValid_SO(log_valid), .LogId_DO(log_id), .LogAddr_DO(log_addr),
      .LogLen_DO(log_len), .LogIsWrite_SO(log_is_write), .DropCnt_DO(drop_cnt)
   );
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic drive(input logic awv, input logic arv, input logic [7:0] awi, input logic [7:0] ari);
      aw_valid = awv; aw_ready = awv; aw_id = awi; aw_addr = {24'h100000, awi}; aw_len = 8'h03;
      ar_valid = arv; ar_ready = arv; ar_id = ari; ar_addr = {24'h200000, ari}; ar_len = 8'h07;
   endtask
   task automatic do_reset();
      drive(0, 0, 0, 0);
      clear = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask
   // Edge e pushes id e-1 on both channels; pops alternate AW (even e) / AR (odd e).
   // Once full (edge 8 on), every other capture per channel is dropped.
   task automatic burst(input int n);
      int j;
      for (int e = 1; e <= n; e++) begin
         drive(1, 1, 8'(e-1), 8'(8'h80 | (e-1)));
         tick();
         if (e >= 2) begin
            chk("burst_valid", log_valid, 1);
            chk("burst_is_write", log_is_write, (e % 2 == 0) ? 1 : 0);
            if (e % 2 == 0) begin
               j = e/2 - 1;
               chk("burst_aw_id", log_id, (j <= 7) ? j : 2*j - 7);
            end else begin
               j = (e-1)/2 - 1;
               chk("burst_ar_id", log_id, 8'h80 | ((j <= 6) ? j : 2*j - 6));
            end
         end
      end
      drive(0, 0, 0, 0);
   endtask
   initial begin
      int cnt;
      do_reset();
      chk("rst_valid", log_valid, 0);
      chk("rst_id", log_id, 0);
      chk("rst_addr", log_addr, 0);
      chk("rst_len", log_len, 0);
      chk("rst_is_write", log_is_write, 0);
      chk("rst_drop", drop_cnt, 0);
      // valid without ready is not a handshake
      aw_valid = 1'b1; aw_id = 8'h77;
      tick();
      aw_valid = 1'b0;
      tick();
      chk("no_ready_valid", log_valid, 0);
      tick();
      chk("no_ready_valid2", log_valid, 0);
      // single AW, 2-cycle latency
      drive(1, 0, 8'h05, 0);
      aw_addr = 32'h1000_0000;
      tick();
      drive(0, 0, 0, 0);
      chk("aw_lat1_valid", log_valid, 0);
      tick();
      chk("aw_valid", log_valid, 1);
      chk("aw_id", log_id, 8'h05);
      chk("aw_addr", log_addr, 32'h1000_0000);
      chk("aw_len", log_len, 8'h03);
      chk("aw_is_write", log_is_write, 1);
      tick();
      chk("aw_one_cycle", log_valid, 0);
      chk("aw_hold_id", log_id, 8'h05);
      // simultaneous channels after reset
      do_reset();
      drive(1, 1, 8'h11, 8'h22);
      tick();
      drive(0, 0, 0, 0);
      tick();
      chk("sim_first_valid", log_valid, 1);
      chk("sim_first_is_write", log_is_write, 1);
      chk("sim_first_id", log_id, 8'h11);
      tick();
      chk("sim_second_valid", log_valid, 1);
      chk("sim_second_is_write", log_is_write, 0);
      chk("sim_second_id", log_id, 8'h22);
      chk("sim_second_addr", log_addr, 32'h2000_0022);
      chk("sim_second_len", log_len, 8'h07);
      tick();
      chk("sim_idle", log_valid, 0);
      // fairness over 20 cycles
      do_reset();
      burst(20);
      // drops over 10 cycles: 20 captures, 9 emitted, 8 held, 3 dropped
      do_reset();
      burst(10);
      chk("drop_cnt", drop_cnt, EXP_DROP);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (log_valid) cnt++;
      end
      chk("drain_count", cnt, 8);
      chk("drop_after_drain", drop_cnt, EXP_DROP);
      // clear with 3 entries per FIFO and an AW handshake in the clear cycle
      do_reset();
      burst(5);
      clear = 1'b1;
      drive(1, 0, 8'hEE, 0);
      tick();
      clear = 1'b0;
      drive(0, 0, 0, 0);
      chk("clr_valid", log_valid, 0);
      chk("clr_drop", drop_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("clr_quiet", log_valid, 0);
      end
      drive(1, 1, 8'h33, 8'h44);
      tick();
      drive(0, 0, 0, 0);
      tick();
      chk("clr_next_is_write", log_is_write, 1);
      chk("clr_next_id", log_id, 8'h33);
      tick();
      chk("clr_then_ar_id", log_id, 8'h44);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
